accel_tcdm_streamer: RTL and testbench
======================================

// Module: accel_tcdm_streamer
// PURPOSE
//  Load-stream engine feeding the accelerator datapath from TCDM through the accelerator's master port.
//  Generates a strided sequence of word reads and buffers the in-order responses in a FIFO.
//  Presents them as a valid/ready stream; bounds outstanding reads by the free FIFO space.
//  Programmed by the accelerator config register stage (base, stride, count, start); reports busy/done back.
// PARAMETERS
//  ADDR_WIDTH  32  TCDM byte-address width
//  DATA_WIDTH  32  TCDM word width; be is DATA_WIDTH/8 bits
//  CNT_WIDTH   16  width of the transfer word count
//  FIFO_DEPTH  4   response buffer entries (power of 2, >=2); also the max number of outstanding reads
// PORTS
//  clk_i           in   1           clock, all logic rising-edge
//  rst_i           in   1           synchronous, active-high reset
//  cfg_start_i     in   1           single-cycle start pulse; sampled only in IDLE
//  cfg_base_i      in   ADDR_WIDTH  first byte address
//  cfg_stride_i    in   ADDR_WIDTH  signed byte stride between words
//  cfg_count_i     in   CNT_WIDTH   words to fetch; 0 is legal
//  busy_o          out  1           high from the cycle after an accepted start until done_o
//  done_o          out  1           1-cycle pulse: last word popped by the consumer (or count==0)
//  tcdm_req_o      out  1           read request
//  tcdm_add_o      out  ADDR_WIDTH  request byte address
//  tcdm_wen_o      out  1           constant 1 (read)
//  tcdm_wdata_o    out  DATA_WIDTH  constant 0
//  tcdm_be_o       out  DATA_WIDTH/8  all ones
//  tcdm_gnt_i      in   1           grant; request transfers on req&&gnt
//  tcdm_r_valid_i  in   1           read response valid; responses return in request order
//  tcdm_r_rdata_i  in   DATA_WIDTH  read data
//  strm_valid_o    out  1           stream word available (FIFO not empty)
//  strm_ready_i    in   1           consumer accepts; pop on valid&&ready
//  strm_data_o     out  DATA_WIDTH  FIFO head
// BEHAVIOUR
//  Reset: state=IDLE, busy_o=0, done_o=0, tcdm_req_o=0, strm_valid_o=0, counters 0, FIFO empty.
//    tcdm_add_o=0 (data outputs don't-care while invalid, but reset to 0).
//  FSM: IDLE -> ISSUE on cfg_start_i && cfg_count_i!=0 (latch base/stride/count).
//    IDLE -> DONE on cfg_start_i && cfg_count_i==0 (no TCDM traffic).
//    ISSUE -> DRAIN when the last request is granted.
//    DRAIN -> DONE when the last word is popped and outstanding==0.
//    DONE -> IDLE after 1 cycle; done_o=1 exactly in DONE.
//  cfg_start_i outside IDLE is ignored; config is not re-sampled mid-transfer.
//  Credit rule: tcdm_req_o = (state==ISSUE) && (outstanding + fifo_count < FIFO_DEPTH).
//    Terms are counted before this cycle's updates; req is driven from registers only.
//  req is held with a stable address until gnt (no retraction).
//  On req&&gnt: addr += stride (mod 2^ADDR_WIDTH, wraps silently); issued++; outstanding++.
//  On r_valid: push r_rdata; outstanding--. Grant and response in the same cycle both apply.
//    outstanding is then unchanged.
//  Push and pop in the same cycle are both allowed, including when the FIFO is full.
//    Credits make push-when-full impossible.
//  r_valid while outstanding==0 (e.g. stale response after mid-transfer reset) is dropped; assert in sim.
//  Latency: first request the cycle after start is accepted.
//    First strm_valid_o the cycle after its r_valid (FIFO registered).
//  Throughput: 1 word/cycle sustained when gnt=1, r_valid one cycle after gnt, and ready=1.
//  Reset mid-transfer: all state cleared next edge; in-flight responses dropped per rule above.
// STRUCTURE
//  accel_pkg: ADDR_WIDTH/DATA_WIDTH defaults, streamer_state_e {IDLE, ISSUE, DRAIN, DONE}.
//  Sub-module accel_stream_fifo: sync FIFO, DEPTH/WIDTH params.
//    Ports: push, pop, data in/out, empty, full, count; same-cycle push/pop when full.
//  Top: FSM, address/issue counter, outstanding counter (log2(FIFO_DEPTH)+1 bits).
// TESTING
//  1. base=0x100, stride=4, count=8, gnt=1, 1-cycle response, ready=1.
//     -> addrs 0x100..0x11C, 8 words in order, done_o 1 pulse, busy_o low after.
//  2. count=0 start -> no tcdm_req_o ever; done_o pulses; busy_o stays 0 apart from the DONE cycle.
//  3. ready=0 throughout, count=10, FIFO_DEPTH=4 -> exactly 4 requests granted then req=0.
//     Releasing ready resumes; all 10 words delivered in order.
//  4. stride=-4 (0xFFFFFFFC), base=0x4, count=3 -> addrs 0x4, 0x0, 0xFFFFFFFC; no error.
//  5. Random gnt (50%), response delay 1 cycle.
//     -> req held stable until gnt; data order matches address order; outstanding never exceeds FIFO_DEPTH.
//  6. rst_i asserted mid-transfer with 2 reads outstanding -> outputs return to reset values next cycle.
//     Late r_valid is dropped; a new start then runs cleanly.

Source files
------------

// File: rtl/accel_tcdm_streamer_pkg.sv
// Shared defaults and state encoding for the TCDM load streamer.
package accel_tcdm_streamer_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 32;
  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned CNT_WIDTH_DEF  = 16;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } streamer_state_e;

endpackage

// File: rtl/accel_tcdm_streamer_if.sv
// TCDM master bus and outgoing valid/ready word stream used by the streamer.
interface accel_tcdm_if import accel_tcdm_streamer_pkg::*; #(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                      req;
  logic [ADDR_WIDTH-1:0]     add;
  logic                      wen;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   be;
  logic                      gnt;
  logic                      r_valid;
  logic [DATA_WIDTH-1:0]     r_rdata;

  modport master (output req, add, wen, wdata, be, input gnt, r_valid, r_rdata);
  modport slave  (input req, add, wen, wdata, be, output gnt, r_valid, r_rdata);
endinterface

interface accel_strm_if import accel_tcdm_streamer_pkg::*; #(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, data, input ready);
  modport slave  (input valid, data, output ready);
endinterface

// File: rtl/accel_tcdm_streamer_fifo.sv
// Synchronous response FIFO; a push is accepted while full if a pop happens in the same cycle.
module accel_stream_fifo import accel_tcdm_streamer_pkg::*; #(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned WIDTH = DATA_WIDTH_DEF,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [PTR_W:0]   count_o
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   cnt_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != FULL_CNT) || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage holds payload only, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign count_o = cnt_q;

endmodule

// File: rtl/accel_tcdm_streamer.sv
// Strided TCDM read engine: issues word reads under a FIFO-space credit limit and streams responses out.
module accel_tcdm_streamer import accel_tcdm_streamer_pkg::*; #(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_start_i,
  input  logic [ADDR_WIDTH-1:0] cfg_base_i,
  input  logic [ADDR_WIDTH-1:0] cfg_stride_i,
  input  logic [CNT_WIDTH-1:0]  cfg_count_i,
  output logic                  busy_o,
  output logic                  done_o,
  accel_tcdm_if.master          tcdm_mst,
  accel_strm_if.master          strm_mst
);

  localparam int unsigned   OUT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [OUT_W:0] DEPTH_LIM = (OUT_W+1)'(FIFO_DEPTH);

  streamer_state_e       state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [CNT_WIDTH-1:0]  issue_left_q, issue_left_d;
  logic [CNT_WIDTH-1:0]  pop_left_q, pop_left_d;
  logic [OUT_W-1:0]      out_q, out_d;

  logic                  req;
  logic                  gnt_fire, rsp_fire, pop_fire;
  logic                  fifo_empty, fifo_full;
  logic [OUT_W-1:0]      fifo_cnt;
  logic [OUT_W:0]        inflight;

  // Credits come from registered counts only, so req never depends on this cycle's gnt.
  assign inflight = {1'b0, out_q} + {1'b0, fifo_cnt};
  assign req      = (state_q == ISSUE) && (inflight < DEPTH_LIM);
  assign gnt_fire = req && tcdm_mst.gnt;
  assign rsp_fire = tcdm_mst.r_valid && (out_q != '0);
  assign pop_fire = strm_mst.ready && !fifo_empty;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    issue_left_d = issue_left_q;
    pop_left_d   = pop_left_q;
    out_d        = out_q;

    case ({gnt_fire, rsp_fire})
      2'b10:   out_d = out_q + OUT_W'(1);
      2'b01:   out_d = out_q - OUT_W'(1);
      default: out_d = out_q;
    endcase

    if (gnt_fire) begin
      addr_d       = addr_q + stride_q;
      issue_left_d = issue_left_q - CNT_WIDTH'(1);
    end
    if (pop_fire && (pop_left_q != '0)) pop_left_d = pop_left_q - CNT_WIDTH'(1);

    unique case (state_q)
      IDLE: begin
        if (cfg_start_i) begin
          if (cfg_count_i != '0) begin
            state_d      = ISSUE;
            addr_d       = cfg_base_i;
            issue_left_d = cfg_count_i;
            pop_left_d   = cfg_count_i;
          end else begin
            state_d = DONE;
          end
        end
      end
      ISSUE: if (gnt_fire && (issue_left_q == CNT_WIDTH'(1))) state_d = DRAIN;
      DRAIN: if (pop_fire && (pop_left_q == CNT_WIDTH'(1)) && (out_q == '0)) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      issue_left_q <= '0;
      pop_left_q   <= '0;
      out_q        <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_left_q <= issue_left_d;
      pop_left_q   <= pop_left_d;
      out_q        <= out_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if ((state_q == IDLE) && cfg_start_i) stride_q <= cfg_stride_i;
  end

  accel_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rsp_fire),
    .pop_i   (pop_fire),
    .data_i  (tcdm_mst.r_rdata),
    .data_o  (strm_mst.data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_cnt)
  );

  assign tcdm_mst.req   = req;
  assign tcdm_mst.add   = addr_q;
  assign tcdm_mst.wen   = 1'b1;
  assign tcdm_mst.wdata = '0;
  assign tcdm_mst.be    = '1;
  assign strm_mst.valid = !fifo_empty;
  assign busy_o         = (state_q != IDLE);
  assign done_o         = (state_q == DONE);

  // Stale responses are tolerated only while idle (e.g. after a mid-transfer reset).
  assert property (@(posedge clk_i) disable iff (rst_i)
    !(tcdm_mst.r_valid && (out_q == '0) && (state_q != IDLE)));
  assert property (@(posedge clk_i) disable iff (rst_i)
    !(rsp_fire && fifo_full && !pop_fire));

endmodule

// File: tb/tb_accel_tcdm_streamer.sv
// Self-checking bench: directed vector table, hand sequences, and random transfers vs. a queue model.
module tb_accel_tcdm_streamer;
  import accel_tcdm_streamer_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int FD = 4;

  logic clk = 1'b0;
  logic rst;
  logic cfg_start;
  logic [AW-1:0] cfg_base, cfg_stride;
  logic [CW-1:0] cfg_count;
  logic busy, done;

  always #5 clk = ~clk;

  accel_tcdm_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) tcdm ();
  accel_strm_if #(.DATA_WIDTH(DW)) strm ();

  accel_tcdm_streamer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .FIFO_DEPTH(FD)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cfg_start_i  (cfg_start),
    .cfg_base_i   (cfg_base),
    .cfg_stride_i (cfg_stride),
    .cfg_count_i  (cfg_count),
    .busy_o       (busy),
    .done_o       (done),
    .tcdm_mst     (tcdm),
    .strm_mst     (strm)
  );

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] stride;
    int            count;
    logic [AW-1:0] last_addr;
  } vec_t;
  vec_t tbl [5];

  int n_tests = 0;
  int n_fail  = 0;

  // Model / bookkeeping state
  int cyc = 0;
  int gnt_pct, rdy_pct;
  bit hold_resp;
  logic [AW-1:0] exp_base, exp_stride, last_add;
  int exp_cnt;
  int n_grant, n_resp, n_pop, n_done, n_busy, n_req_seen, max_infl;
  int start_cyc, first_req_cyc, first_grant_cyc, last_grant_cyc, first_rv_cyc, first_valid_cyc;
  bit grant_prev, prev_req_wait;
  logic [AW-1:0] prev_add;
  logic [DW-1:0] dq [$];
  logic [DW-1:0] pend [$];

  function automatic logic [DW-1:0] mkdata(logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample outputs at negedge, update the model, then drive inputs for the next edge.
  task automatic cycle();
    logic [AW-1:0] ea;
    @(negedge clk);
    cyc++;
    if ((n_grant - n_pop) > max_infl) max_infl = n_grant - n_pop;
    if (strm.valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (tcdm.req && first_req_cyc < 0) first_req_cyc = cyc;
    if (done) n_done++;
    if (busy) n_busy++;
    if (tcdm.req) n_req_seen++;
    if (prev_req_wait) begin
      chk("req_held", tcdm.req, 1);
      chk("add_held", tcdm.add, prev_add);
    end

    cfg_start = 1'b0;
    tcdm.r_valid = 1'b0;
    tcdm.r_rdata = $urandom;
    if (!hold_resp && grant_prev && pend.size() > 0) begin
      tcdm.r_valid = 1'b1;
      tcdm.r_rdata = pend.pop_front();
      n_resp++;
      if (first_rv_cyc < 0) first_rv_cyc = cyc;
    end
    tcdm.gnt    = ($urandom_range(0, 99) < gnt_pct);
    strm.ready  = ($urandom_range(0, 99) < rdy_pct);

    grant_prev = tcdm.req && tcdm.gnt;
    if (grant_prev) begin
      ea = exp_base + exp_stride * AW'(n_grant);
      chk("addr", tcdm.add, ea);
      pend.push_back(mkdata(tcdm.add));
      dq.push_back(mkdata(ea));
      if (n_grant == 0) first_grant_cyc = cyc;
      last_grant_cyc = cyc;
      last_add = tcdm.add;
      n_grant++;
    end
    prev_req_wait = tcdm.req && !tcdm.gnt;
    prev_add      = tcdm.add;

    if (strm.valid && strm.ready) begin
      chk("pop_expected", (dq.size() != 0), 1);
      if (dq.size() != 0) chk("data", strm.data, dq.pop_front());
      n_pop++;
    end
  endtask

  task automatic begin_xfer(input logic [AW-1:0] b, input logic [AW-1:0] s, input int c,
                            input int gp, input int rp);
    exp_base = b; exp_stride = s; exp_cnt = c;
    gnt_pct = gp; rdy_pct = rp;
    n_grant = 0; n_resp = 0; n_pop = 0; n_done = 0; n_busy = 0; n_req_seen = 0; max_infl = 0;
    first_req_cyc = -1; first_grant_cyc = -1; last_grant_cyc = -1;
    first_rv_cyc = -1; first_valid_cyc = -1;
    grant_prev = 1'b0; prev_req_wait = 1'b0;
    dq.delete(); pend.delete();
    cfg_base = b; cfg_stride = s; cfg_count = CW'(c);
    cfg_start = 1'b1;
    start_cyc = cyc;
  endtask

  task automatic finish_xfer(input int budget);
    int t0;
    t0 = cyc;
    while (n_done == 0 && (cyc - t0) < budget) cycle();
    chk("done_seen", n_done, 1);
    chk("grants", n_grant, exp_cnt);
    chk("pops", n_pop, exp_cnt);
    if (exp_cnt == 0) begin
      chk("no_req", n_req_seen, 0);
      chk("busy_cycles", n_busy, 1);
    end else begin
      chk("inflight_le_depth", (max_infl <= FD), 1);
      chk("req_latency", first_req_cyc - start_cyc, 1);
      chk("valid_latency", first_valid_cyc - first_rv_cyc, 1);
    end
    cycle();
    chk("done_one_pulse", n_done, 1);
    chk("busy_after_done", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{32'h0000_0100, 32'h0000_0004, 8, 32'h0000_011C};
    tbl[1] = '{32'h0000_0004, 32'hFFFF_FFFC, 3, 32'hFFFF_FFFC};
    tbl[2] = '{32'h0000_2000, 32'h0000_0010, 5, 32'h0000_2040};
    tbl[3] = '{32'hFFFF_FFF8, 32'h0000_0008, 3, 32'h0000_0008};
    tbl[4] = '{32'h0000_0040, 32'h0000_0000, 1, 32'h0000_0040};

    rst = 1'b1; cfg_start = 1'b0; cfg_base = '0; cfg_stride = '0; cfg_count = '0;
    tcdm.gnt = 1'b0; tcdm.r_valid = 1'b0; tcdm.r_rdata = '0; strm.ready = 1'b0;
    gnt_pct = 100; rdy_pct = 100; hold_resp = 1'b0;
    begin_xfer('0, '0, 0, 100, 100);
    cfg_start = 1'b0;

    // Reset state
    repeat (3) cycle();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", tcdm.req, 0);
    chk("rst_valid", strm.valid, 0);
    chk("rst_add", tcdm.add, 0);
    chk("rst_wen", tcdm.wen, 1);
    chk("rst_be", tcdm.be, 4'hF);
    rst = 1'b0;
    cycle();

    // Directed table: full grant, 1-cycle response, always ready
    for (int i = 0; i < 5; i++) begin
      begin_xfer(tbl[i].base, tbl[i].stride, tbl[i].count, 100, 100);
      finish_xfer(200);
      chk("last_addr", last_add, tbl[i].last_addr);
      chk("throughput", last_grant_cyc - first_grant_cyc, tbl[i].count - 1);
    end

    // count==0: straight to DONE with no traffic
    begin_xfer(32'h0000_0800, 32'h4, 0, 100, 100);
    finish_xfer(20);

    // Consumer stalled: credits cap outstanding+buffered at FIFO_DEPTH
    begin_xfer(32'h0000_1000, 32'h4, 10, 100, 0);
    repeat (20) cycle();
    chk("stall_grants", n_grant, FD);
    chk("stall_req_off", tcdm.req, 0);
    chk("stall_valid", strm.valid, 1);
    chk("stall_busy", busy, 1);
    rdy_pct = 100;
    finish_xfer(200);

    // Random grant, random ready
    for (int k = 0; k < 6; k++) begin
      logic [AW-1:0] b, s;
      b = $urandom & 32'hFFFF_FFFC;
      case ($urandom_range(0, 3))
        0: s = 32'h4;
        1: s = 32'hFFFF_FFFC;
        2: s = 32'h40;
        default: s = $urandom & 32'hFFFF_FFFC;
      endcase
      begin_xfer(b, s, $urandom_range(1, 24), 50, $urandom_range(30, 100));
      finish_xfer(2000);
    end

    // Mid-transfer reset with two reads outstanding, then a stale response
    begin_xfer(32'h0000_0300, 32'h4, 8, 100, 0);
    hold_resp = 1'b1;
    for (int t = 0; t < 20 && n_grant < 2; t++) cycle();
    cycle();
    rst = 1'b1;
    cycle();
    chk("mid_rst_req", tcdm.req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_valid", strm.valid, 0);
    chk("mid_rst_add", tcdm.add, 0);
    rst = 1'b0;
    tcdm.r_valid = 1'b1;
    tcdm.r_rdata = 32'hDEAD_BEEF;
    hold_resp = 1'b0;
    grant_prev = 1'b0;
    prev_req_wait = 1'b0;
    cycle();
    chk("stale_dropped", strm.valid, 0);
    chk("stale_idle", busy, 0);
    begin_xfer(32'h0000_0500, 32'h8, 6, 100, 100);
    finish_xfer(200);
    chk("post_rst_last_addr", last_add, 32'h0000_0528);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
